pipe_cu_hz: RTL and testbench

- ID-stage control unit for the 5-stage pipelined MIPS core. It succeeds the single-cycle decoder with four additions:
  - parametrised register-address width;
  - internal EX/MEM destination tracking;
  - forwarding-select generation and load-use stall detection;
  - a multi-cycle MUL issue FSM.
- Sits between the IF/ID register and the ID/EX register. It drives the datapath muxes and the PC/IR write enable.

---
 rtl/pipe_pkg.sv | 77 +++++++
 rtl/pipe_cu_hz_if.sv | 36 +++
 rtl/cu_decode.sv | 73 +++++++
 rtl/pipe_cu_hz.sv | 143 ++++++++++++++
 tb/tb_pipe_cu_hz.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings and control payload for the pipelined MIPS ID-stage control unit.
package pipe_pkg;

   // Primary opcodes (instruction[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_MUL   = 6'b011100;

   // Function codes (instruction[5:0])
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_XOR = 6'b100110;
   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_SRL = 6'b000010;
   localparam logic [5:0] FN_SRA = 6'b000011;
   localparam logic [5:0] FN_JR  = 6'b001000;
   localparam logic [5:0] FN_MUL = 6'b000010;

   // ALU operation codes
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0100;
   localparam logic [3:0] ALU_AND = 4'b0001;
   localparam logic [3:0] ALU_OR  = 4'b0101;
   localparam logic [3:0] ALU_XOR = 4'b0010;
   localparam logic [3:0] ALU_LUI = 4'b0110;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_SRL = 4'b0111;
   localparam logic [3:0] ALU_SRA = 4'b1111;
   localparam logic [3:0] ALU_MUL = 4'b1000;

   // Operand forwarding selects
   localparam logic [1:0] FWD_RF   = 2'b00;
   localparam logic [1:0] FWD_EXE  = 2'b01;
   localparam logic [1:0] FWD_MALU = 2'b10;
   localparam logic [1:0] FWD_MMEM = 2'b11;

   // Next-PC source selects
   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;
   localparam logic [1:0] PC_JR  = 2'b10;
   localparam logic [1:0] PC_JMP = 2'b11;

   typedef enum logic {MUL_IDLE, MUL_BUSY} mul_state_t;

   // Raw (ungated) decode result
   typedef struct packed {
      logic       wreg;
      logic       m2reg;
      logic       wmem;
      logic [3:0] aluc;
      logic       shift;
      logic       aluimm;
      logic       sext;
      logic       regrt;
      logic       jal;
      logic       jr;
      logic       j;
      logic       beq;
      logic       bne;
      logic       mul;
      logic       uses_rs;
      logic       uses_rt;
   } ctrl_t;

endpackage

// File: rtl/pipe_cu_hz_if.sv
// IF/ID-side fields in, datapath controls out, for the ID-stage control unit.
interface pipe_cu_hz_if #(parameter int unsigned RA_W = 5);
   logic [5:0]      op;
   logic [5:0]      func;
   logic [RA_W-1:0] rs;
   logic [RA_W-1:0] rt;
   logic [RA_W-1:0] rd;
   logic            rsrtequ;
   logic            wreg;
   logic            m2reg;
   logic            wmem;
   logic [3:0]      aluc;
   logic            shift;
   logic            aluimm;
   logic            sext;
   logic            regrt;
   logic            jal;
   logic [1:0]      pcsource;
   logic [1:0]      fwda;
   logic [1:0]      fwdb;
   logic            wpcir;
   logic            mul_start;
   logic            busy;

   modport master (
      output op, func, rs, rt, rd, rsrtequ,
      input  wreg, m2reg, wmem, aluc, shift, aluimm, sext, regrt, jal,
             pcsource, fwda, fwdb, wpcir, mul_start, busy
   );

   modport slave (
      input  op, func, rs, rt, rd, rsrtequ,
      output wreg, m2reg, wmem, aluc, shift, aluimm, sext, regrt, jal,
             pcsource, fwda, fwdb, wpcir, mul_start, busy
   );
endinterface

// File: rtl/cu_decode.sv
// Pure op/func decoder: raw controls plus source-register usage flags.
module cu_decode
   import pipe_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] func,
   output ctrl_t      ctrl
);

   logic r_type;
   logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
   logic i_addi, i_andi, i_ori, i_xori, i_lw, i_sw, i_beq, i_bne, i_lui, i_j, i_jal, i_mul;
   logic r_alu, i_shift;

   // Instruction recognition
   always_comb begin
      r_type  = (op == OP_RTYPE);
      i_add   = r_type & (func == FN_ADD);
      i_sub   = r_type & (func == FN_SUB);
      i_and   = r_type & (func == FN_AND);
      i_or    = r_type & (func == FN_OR);
      i_xor   = r_type & (func == FN_XOR);
      i_sll   = r_type & (func == FN_SLL);
      i_srl   = r_type & (func == FN_SRL);
      i_sra   = r_type & (func == FN_SRA);
      i_jr    = r_type & (func == FN_JR);
      i_addi  = (op == OP_ADDI);
      i_andi  = (op == OP_ANDI);
      i_ori   = (op == OP_ORI);
      i_xori  = (op == OP_XORI);
      i_lw    = (op == OP_LW);
      i_sw    = (op == OP_SW);
      i_beq   = (op == OP_BEQ);
      i_bne   = (op == OP_BNE);
      i_lui   = (op == OP_LUI);
      i_j     = (op == OP_J);
      i_jal   = (op == OP_JAL);
      i_mul   = (op == OP_MUL) & (func == FN_MUL);
      i_shift = i_sll | i_srl | i_sra;
      r_alu   = i_add | i_sub | i_and | i_or | i_xor | i_shift;
   end

   // Raw control generation
   always_comb begin
      ctrl         = '0;
      ctrl.wreg    = r_alu | i_mul | i_addi | i_andi | i_ori | i_xori | i_lw | i_lui | i_jal;
      ctrl.m2reg   = i_lw;
      ctrl.wmem    = i_sw;
      ctrl.shift   = i_shift;
      ctrl.aluimm  = i_addi | i_andi | i_ori | i_xori | i_lw | i_sw | i_lui;
      ctrl.sext    = i_addi | i_lw | i_sw | i_beq | i_bne;
      ctrl.regrt   = i_addi | i_andi | i_ori | i_xori | i_lw | i_lui;
      ctrl.jal     = i_jal;
      ctrl.jr      = i_jr;
      ctrl.j       = i_j;
      ctrl.beq     = i_beq;
      ctrl.bne     = i_bne;
      ctrl.mul     = i_mul;
      ctrl.uses_rs = ~(i_shift | i_lui | i_j | i_jal);
      ctrl.uses_rt = r_alu | i_mul | i_sw | i_beq | i_bne;
      if (i_sub | i_beq | i_bne)   ctrl.aluc = ALU_SUB;
      else if (i_and | i_andi)     ctrl.aluc = ALU_AND;
      else if (i_or | i_ori)       ctrl.aluc = ALU_OR;
      else if (i_xor | i_xori)     ctrl.aluc = ALU_XOR;
      else if (i_lui)              ctrl.aluc = ALU_LUI;
      else if (i_sll)              ctrl.aluc = ALU_SLL;
      else if (i_srl)              ctrl.aluc = ALU_SRL;
      else if (i_sra)              ctrl.aluc = ALU_SRA;
      else if (i_mul)              ctrl.aluc = ALU_MUL;
      else                         ctrl.aluc = ALU_ADD;
   end

endmodule

// File: rtl/pipe_cu_hz.sv
// ID-stage control unit: decode, EX/MEM destination tracking, forwarding,
// load-use stall and multi-cycle MUL issue.
module pipe_cu_hz
   import pipe_pkg::*;
#(
   parameter int unsigned RA_W       = 5,
   parameter int unsigned MUL_CYCLES = 4
)(
   input  logic         clock,
   input  logic         reset,
   pipe_cu_hz_if.slave  bus
);

   localparam int unsigned       CNT_W    = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MUL_CYCLES - 2);

   ctrl_t            dec;
   logic             ewreg, em2reg, mwreg, mm2reg;
   logic [RA_W-1:0]  ern, mrn, drn;
   logic             loaduse, mul_pend, go, start, wreg_g;
   mul_state_t       state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             done, done_n;

   cu_decode u_decode (
      .op   (bus.op),
      .func (bus.func),
      .ctrl (dec)
   );

   // Forward select for one source register, EX result taking priority over MEM
   function automatic logic [1:0] fwd_sel(
      input logic [RA_W-1:0] src,
      input logic            e_w, e_m,
      input logic [RA_W-1:0] e_rn,
      input logic            m_w, m_m,
      input logic [RA_W-1:0] m_rn
   );
      logic [1:0] sel;
      sel = FWD_RF;
      if (e_w && (e_rn != '0) && (e_rn == src) && !e_m)      sel = FWD_EXE;
      else if (m_w && (m_rn != '0) && (m_rn == src) && !m_m) sel = FWD_MALU;
      else if (m_w && (m_rn != '0) && (m_rn == src) && m_m)  sel = FWD_MMEM;
      return sel;
   endfunction

   // Hazard detection and gated datapath controls
   always_comb begin
      loaduse  = ewreg & em2reg & (ern != '0) &
                 (((ern == bus.rs) & dec.uses_rs) | ((ern == bus.rt) & dec.uses_rt));
      mul_pend = dec.mul & (state == MUL_IDLE) & ~done;
      go       = ~(loaduse | (state == MUL_BUSY) | mul_pend);
      start    = dec.mul & (state == MUL_IDLE) & ~done & ~loaduse;
      wreg_g   = dec.wreg & go;
      drn      = dec.jal ? RA_W'(31) : (dec.regrt ? bus.rt : bus.rd);

      bus.m2reg     = dec.m2reg;
      bus.aluc      = dec.aluc;
      bus.shift     = dec.shift;
      bus.aluimm    = dec.aluimm;
      bus.sext      = dec.sext;
      bus.regrt     = dec.regrt;
      bus.jal       = dec.jal;
      bus.busy      = (state == MUL_BUSY);
      bus.wreg      = wreg_g;
      bus.wmem      = dec.wmem & go;
      bus.mul_start = start;
      bus.wpcir     = go;
      bus.pcsource  = PC_SEQ;
      if (go) begin
         bus.pcsource[0] = (dec.beq & bus.rsrtequ) | (dec.bne & ~bus.rsrtequ) | dec.j | dec.jal;
         bus.pcsource[1] = dec.jr | dec.j | dec.jal;
      end
      bus.fwda = fwd_sel(bus.rs, ewreg, em2reg, ern, mwreg, mm2reg, mrn);
      bus.fwdb = fwd_sel(bus.rt, ewreg, em2reg, ern, mwreg, mm2reg, mrn);

      // Quiet, non-stalling outputs while reset is held
      if (reset) begin
         bus.wreg      = 1'b0;
         bus.wmem      = 1'b0;
         bus.mul_start = 1'b0;
         bus.pcsource  = PC_SEQ;
         bus.fwda      = FWD_RF;
         bus.fwdb      = FWD_RF;
         bus.wpcir     = 1'b1;
      end
   end

   // MUL issue FSM next state; done blocks re-trigger on the held mul's final cycle
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      done_n  = done;
      case (state)
         MUL_IDLE: begin
            if (start) begin
               if (CNT_LOAD == '0) begin
                  done_n = 1'b1;
               end else begin
                  state_n = MUL_BUSY;
                  cnt_n   = CNT_LOAD;
               end
            end else if (go) begin
               done_n = 1'b0;
            end
         end
         MUL_BUSY: begin
            cnt_n = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               state_n = MUL_IDLE;
               done_n  = 1'b1;
            end
         end
         default: state_n = MUL_IDLE;
      endcase
   end

   // FSM state and EX/MEM destination tracking
   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= MUL_IDLE;
         cnt    <= '0;
         done   <= 1'b0;
         ewreg  <= 1'b0;
         em2reg <= 1'b0;
         ern    <= '0;
         mwreg  <= 1'b0;
         mm2reg <= 1'b0;
         mrn    <= '0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         done   <= done_n;
         ewreg  <= wreg_g;
         em2reg <= dec.m2reg;
         ern    <= drn;
         mwreg  <= ewreg;
         mm2reg <= em2reg;
         mrn    <= ern;
      end
   end

endmodule

// File: tb/tb_pipe_cu_hz.sv
// Scoreboard bench for pipe_cu_hz: one instruction per cycle, expectations queued at drive time.
module tb_pipe_cu_hz;

   localparam logic [5:0] T_R = 6'h00, T_LW = 6'h23, T_SW = 6'h2B, T_BEQ = 6'h04, T_BNE = 6'h05;
   localparam logic [5:0] T_J = 6'h02, T_JAL = 6'h03, T_ADDI = 6'h08, T_LUI = 6'h0F, T_MUL = 6'h1C;
   localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26;
   localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_JR = 6'h08, F_MUL = 6'h02;

   typedef struct {
      string      tag;
      logic       wp, wr, wm, ms, bz;
      logic [1:0] pcs, fa, fb;
      int         alu;
   } exp_t;

   logic  clock;
   logic  reset;
   exp_t  sb[$];
   exp_t  cur;
   int    n_checks;
   int    n_fails;

   pipe_cu_hz_if #(.RA_W(5)) bus ();

   pipe_cu_hz #(.RA_W(5), .MUL_CYCLES(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one instruction for one cycle and queue its expected controls
   task automatic issue(input string tag, input logic rst, input logic [5:0] op, input logic [5:0] func,
                        input int rs, input int rt, input int rd, input logic eq,
                        input logic wp, input logic wr, input logic wm, input logic [1:0] pcs,
                        input logic [1:0] fa, input logic [1:0] fb, input logic ms, input logic bz,
                        input int alu);
      exp_t e;
      @(posedge clock);
      #1;
      reset       = rst;
      bus.op      = op;
      bus.func    = func;
      bus.rs      = 5'(rs);
      bus.rt      = 5'(rt);
      bus.rd      = 5'(rd);
      bus.rsrtequ = eq;
      e.tag = tag; e.wp = wp; e.wr = wr; e.wm = wm; e.pcs = pcs;
      e.fa = fa; e.fb = fb; e.ms = ms; e.bz = bz; e.alu = alu;
      sb.push_back(e);
   endtask

   // Compare DUT outputs against the oldest queued expectation
   always @(negedge clock) begin
      if (sb.size() > 0) begin
         cur = sb.pop_front();
         check_eq({cur.tag, ".wpcir"},     8'(bus.wpcir),     8'(cur.wp));
         check_eq({cur.tag, ".wreg"},      8'(bus.wreg),      8'(cur.wr));
         check_eq({cur.tag, ".wmem"},      8'(bus.wmem),      8'(cur.wm));
         check_eq({cur.tag, ".pcsource"},  8'(bus.pcsource),  8'(cur.pcs));
         check_eq({cur.tag, ".fwda"},      8'(bus.fwda),      8'(cur.fa));
         check_eq({cur.tag, ".fwdb"},      8'(bus.fwdb),      8'(cur.fb));
         check_eq({cur.tag, ".mul_start"}, 8'(bus.mul_start), 8'(cur.ms));
         check_eq({cur.tag, ".busy"},      8'(bus.busy),      8'(cur.bz));
         if (cur.alu >= 0)
            check_eq({cur.tag, ".aluc"},   8'(bus.aluc),      8'(cur.alu));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fails  = 0;
      reset = 1'b1;
      bus.op = '0; bus.func = '0; bus.rs = '0; bus.rt = '0; bus.rd = '0; bus.rsrtequ = 1'b0;

      //     tag          rst op      func   rs  rt  rd  eq   wp wr wm pcs fa fb ms bz alu
      issue("rst_add",    1, T_R,    F_ADD,  1,  2,  3, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0);
      issue("add_r3",     0, T_R,    F_ADD,  1,  2,  3, 0,   1, 1, 0, 0, 0, 0, 0, 0, 0);
      issue("sub_fwd_e",  0, T_R,    F_SUB,  3,  1,  4, 0,   1, 1, 0, 0, 1, 0, 0, 0, 4);
      issue("lw_r5",      0, T_LW,   F_ADD,  1,  5,  0, 0,   1, 1, 0, 0, 0, 0, 0, 0, 0);
      issue("lu_stall",   0, T_R,    F_ADD,  5,  2,  6, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0);
      issue("lu_mmem",    0, T_R,    F_ADD,  5,  2,  6, 0,   1, 1, 0, 0, 3, 0, 0, 0, 0);
      issue("add_r0",     0, T_R,    F_ADD,  1,  2,  0, 0,   1, 1, 0, 0, 0, 0, 0, 0, 0);
      issue("or_rd_r0",   0, T_R,    F_OR,   0,  0,  8, 0,   1, 1, 0, 0, 0, 0, 0, 0, 5);
      issue("lw_r0",      0, T_LW,   F_ADD,  1,  0,  0, 0,   1, 1, 0, 0, 0, 0, 0, 0, 0);
      issue("r0_nostall", 0, T_R,    F_ADD,  0,  0,  9, 0,   1, 1, 0, 0, 0, 0, 0, 0, 0);
      issue("xor_r11",    0, T_R,    F_XOR,  1,  2, 11, 0,   1, 1, 0, 0, 0, 0, 0, 0, 2);
      issue("and_malu",   0, T_R,    F_AND,  3,  9, 12, 0,   1, 1, 0, 0, 0, 2, 0, 0, 1);
      issue("beq_taken",  0, T_BEQ,  F_ADD,  1,  2,  0, 1,   1, 0, 0, 1, 0, 0, 0, 0, -1);
      issue("bne_not",    0, T_BNE,  F_ADD,  1,  2,  0, 1,   1, 0, 0, 0, 0, 0, 0, 0, -1);
      issue("jr",         0, T_R,    F_JR,  31,  0,  0, 0,   1, 0, 0, 2, 0, 0, 0, 0, -1);
      issue("jal",        0, T_JAL,  F_ADD,  0,  0,  0, 0,   1, 1, 0, 3, 0, 0, 0, 0, -1);
      issue("use_r31",    0, T_R,    F_ADD, 31,  1, 13, 0,   1, 1, 0, 0, 1, 0, 0, 0, 0);
      issue("lw_r14",     0, T_LW,   F_ADD,  2, 14,  0, 0,   1, 1, 0, 0, 0, 0, 0, 0, 0);
      issue("beq_stall",  0, T_BEQ,  F_ADD, 14,  1,  0, 1,   0, 0, 0, 0, 0, 0, 0, 0, -1);
      issue("beq_resume", 0, T_BEQ,  F_ADD, 14,  1,  0, 1,   1, 0, 0, 1, 3, 0, 0, 0, -1);
      issue("lw_r15",     0, T_LW,   F_ADD,  1, 15,  0, 0,   1, 1, 0, 0, 0, 0, 0, 0, 0);
      issue("addi_no_rt", 0, T_ADDI, F_ADD,  1, 15,  0, 0,   1, 1, 0, 0, 0, 0, 0, 0, 0);
      issue("lw_r20",     0, T_LW,   F_ADD,  1, 20,  0, 0,   1, 1, 0, 0, 0, 0, 0, 0, 0);
      issue("sw_stall",   0, T_SW,   F_ADD,  1, 20,  0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0);
      issue("sw_resume",  0, T_SW,   F_ADD,  1, 20,  0, 0,   1, 0, 1, 0, 0, 3, 0, 0, 0);
      issue("mul_c0",     0, T_MUL,  F_MUL,  1,  2,  7, 0,   0, 0, 0, 0, 0, 0, 1, 0, 8);
      issue("mul_c1",     0, T_MUL,  F_MUL,  1,  2,  7, 0,   0, 0, 0, 0, 0, 0, 0, 1, 8);
      issue("mul_c2",     0, T_MUL,  F_MUL,  1,  2,  7, 0,   0, 0, 0, 0, 0, 0, 0, 1, 8);
      issue("mul_c3",     0, T_MUL,  F_MUL,  1,  2,  7, 0,   1, 1, 0, 0, 0, 0, 0, 0, 8);
      issue("use_r7",     0, T_R,    F_ADD,  7,  1, 17, 0,   1, 1, 0, 0, 1, 0, 0, 0, 0);
      issue("mul2_c0",    0, T_MUL,  F_MUL,  1,  2,  7, 0,   0, 0, 0, 0, 0, 0, 1, 0, 8);
      issue("mul2_rst",   1, T_MUL,  F_MUL,  1,  2,  7, 0,   1, 0, 0, 0, 0, 0, 0, 1, 8);
      issue("post_rst",   0, T_R,    F_ADD, 17,  7, 18, 0,   1, 1, 0, 0, 0, 0, 0, 0, 0);
      issue("mul3_c0",    0, T_MUL,  F_MUL,  1,  2,  7, 0,   0, 0, 0, 0, 0, 0, 1, 0, 8);
      issue("mul3_c1",    0, T_MUL,  F_MUL,  1,  2,  7, 0,   0, 0, 0, 0, 0, 0, 0, 1, 8);
      issue("mul3_c2",    0, T_MUL,  F_MUL,  1,  2,  7, 0,   0, 0, 0, 0, 0, 0, 0, 1, 8);
      issue("mul3_c3",    0, T_MUL,  F_MUL,  1,  2,  7, 0,   1, 1, 0, 0, 0, 0, 0, 0, 8);
      issue("sll_fwdb",   0, T_R,    F_SLL,  0,  7, 21, 0,   1, 1, 0, 0, 0, 1, 0, 0, 3);
      issue("sra_fwdb",   0, T_R,    F_SRA,  0, 21, 22, 0,   1, 1, 0, 0, 0, 1, 0, 0, 15);
      issue("lui",        0, T_LUI,  F_ADD,  0, 23,  0, 0,   1, 1, 0, 0, 0, 0, 0, 0, 6);
      issue("lw_r24",     0, T_LW,   F_ADD,  1, 24,  0, 0,   1, 1, 0, 0, 0, 0, 0, 0, 0);
      issue("srl_no_rs",  0, T_R,    F_SRL, 24,  2, 25, 0,   1, 1, 0, 0, 0, 0, 0, 0, 7);
      issue("jump",       0, T_J,    F_ADD,  0,  0,  0, 0,   1, 0, 0, 3, 0, 0, 0, 0, -1);

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
      @(posedge clock);
      #1;
      check_eq("drain", 8'(sb.size()), 8'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
